// File: rtl/lcd_grid_draw_pkg.sv
// Shared definitions for the LCD grid painter: ST7789 commands, FSM states,
// pixel-format and pattern-mode codes.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CASET  = 3'd1,
    RASET  = 3'd2,
    RAMWR  = 3'd3,
    PIXELS = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic PIX_RGB565 = 1'b0;
  localparam logic PIX_RGB888 = 1'b1;

  typedef enum logic [1:0] {
    MODE_COL   = 2'd0,
    MODE_ROW   = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  function automatic logic [1:0] last_byte_idx(input logic fmt);
    return (fmt == PIX_RGB888) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/lcd_grid_draw_if.sv
// Control + SPI byte bus of the grid painter. border_color exists only when
// LCD_GRID_BORDER_EN is defined.
interface lcd_grid_draw_if;
  logic        draw_en;
  logic [1:0]  mode;
  logic [23:0] color_p1;
  logic [23:0] color_p2;
`ifdef LCD_GRID_BORDER_EN
  logic [23:0] border_color;
`endif
  logic        busy;
  logic        done;
  logic        spi_start;
  logic [7:0]  spi_data;
  logic        spi_dc;
  logic        spi_ready;

  modport master (
`ifdef LCD_GRID_BORDER_EN
    input  border_color,
`endif
    input  draw_en, mode, color_p1, color_p2, spi_ready,
    output busy, done, spi_start, spi_data, spi_dc
  );

  modport slave (
`ifdef LCD_GRID_BORDER_EN
    output border_color,
`endif
    output draw_en, mode, color_p1, color_p2, spi_ready,
    input  busy, done, spi_start, spi_data, spi_dc
  );
endinterface

// File: rtl/lcd_grid_draw_pixel_fmt.sv
// Combinational pixel serialiser: picks one byte of a 24-bit colour for
// RGB565 (high byte first) or RGB888 (R, G, B).
module lcd_pixel_fmt
  import lcd_pkg::*;
(
  input  logic [23:0] color,
  input  logic [1:0]  byte_idx,
  input  logic        fmt,
  output logic [7:0]  data
);

  logic [15:0] rgb565_s;

  assign rgb565_s = {color[23:19], color[15:10], color[7:3]};

  // Byte selection for the active pixel format
  always_comb begin
    data = 8'h00;
    if (fmt == PIX_RGB888) begin
      case (byte_idx)
        2'd0:    data = color[23:16];
        2'd1:    data = color[15:8];
        2'd2:    data = color[7:0];
        default: data = 8'h00;
      endcase
    end else begin
      case (byte_idx)
        2'd0:    data = rgb565_s[15:8];
        2'd1:    data = rgb565_s[7:0];
        default: data = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/lcd_grid_draw.sv
// Streams CASET/RASET/RAMWR and a full colour grid to the SPI byte sender.
// Optional per-cell border colour under LCD_GRID_BORDER_EN.
module lcd_grid_draw
  import lcd_pkg::*;
#(
  parameter int GRID_ROWS = 5,
  parameter int GRID_COLS = 8,
  parameter int CELL_W    = 30,
  parameter int CELL_H    = 27,
  parameter int X_OFFSET  = 40,
  parameter int Y_OFFSET  = 53,
  parameter int PIX_FMT   = 0
) (
  input logic            clk,
  input logic            reset,
  lcd_grid_draw_if.master bus
);

  localparam int PXW = (CELL_W    > 1) ? $clog2(CELL_W)    : 1;
  localparam int PYW = (CELL_H    > 1) ? $clog2(CELL_H)    : 1;
  localparam int CXW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int RYW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;

  localparam logic        FMT      = (PIX_FMT != 0) ? PIX_RGB888 : PIX_RGB565;
  localparam logic [1:0]  BIDX_MAX = last_byte_idx(FMT);
  localparam logic [PXW-1:0] PX_MAX  = PXW'(CELL_W - 1);
  localparam logic [PYW-1:0] PY_MAX  = PYW'(CELL_H - 1);
  localparam logic [CXW-1:0] COL_MAX = CXW'(GRID_COLS - 1);
  localparam logic [RYW-1:0] ROW_MAX = RYW'(GRID_ROWS - 1);
  localparam logic [15:0] XS = 16'(X_OFFSET);
  localparam logic [15:0] XE = 16'(X_OFFSET + GRID_COLS * CELL_W - 1);
  localparam logic [15:0] YS = 16'(Y_OFFSET);
  localparam logic [15:0] YE = 16'(Y_OFFSET + GRID_ROWS * CELL_H - 1);

  state_t          state_r, state_nx;
  logic [2:0]      hdr_r, hdr_nx;
  logic [1:0]      bidx_r, bidx_nx;
  logic [PXW-1:0]  px_r, px_nx;
  logic [PYW-1:0]  py_r, py_nx;
  logic [CXW-1:0]  col_r, col_nx;
  logic [RYW-1:0]  row_r, row_nx;
  logic            busy_r, busy_nx, done_r, done_nx, start_r, start_nx;
  logic [7:0]      data_r, data_nx;
  logic            dc_r, dc_nx;
  mode_t           mode_r, mode_nx;
  logic [23:0]     p1_r, p1_nx, p2_r, p2_nx;
  logic            xfer_s, last_s, sel_s;
  logic [23:0]     color_s;
  logic [7:0]      pix_byte_s;
`ifdef LCD_GRID_BORDER_EN
  logic [23:0]     border_r, border_nx;
`endif

  function automatic logic [7:0] coord_byte(input logic [15:0] s, input logic [15:0] e,
                                            input logic [2:0] idx);
    case (idx)
      3'd1:    return s[15:8];
      3'd2:    return s[7:0];
      3'd3:    return e[15:8];
      3'd4:    return e[7:0];
      default: return 8'h00;
    endcase
  endfunction

  assign xfer_s = start_r & bus.spi_ready;
  assign last_s = (bidx_r == BIDX_MAX) && (px_r == PX_MAX) && (col_r == COL_MAX) &&
                  (py_r == PY_MAX) && (row_r == ROW_MAX);

  // Next-state, counter and latch logic; everything holds unless a byte transfers
  always_comb begin
    state_nx = state_r;  hdr_nx = hdr_r;  bidx_nx = bidx_r;
    px_nx = px_r;  col_nx = col_r;  py_nx = py_r;  row_nx = row_r;
    busy_nx = busy_r;  done_nx = 1'b0;  start_nx = start_r;
    mode_nx = mode_r;  p1_nx = p1_r;  p2_nx = p2_r;
`ifdef LCD_GRID_BORDER_EN
    border_nx = border_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.draw_en) begin
          state_nx = CASET;  busy_nx = 1'b1;  start_nx = 1'b1;
          hdr_nx = 3'd0;  bidx_nx = 2'd0;
          px_nx = '0;  col_nx = '0;  py_nx = '0;  row_nx = '0;
          mode_nx = mode_t'(bus.mode);  p1_nx = bus.color_p1;  p2_nx = bus.color_p2;
`ifdef LCD_GRID_BORDER_EN
          border_nx = bus.border_color;
`endif
        end else begin
          busy_nx = 1'b0;  start_nx = 1'b0;
        end
      end
      CASET, RASET: begin
        if (xfer_s && hdr_r == 3'd4) begin
          hdr_nx = 3'd0;
          state_nx = (state_r == CASET) ? RASET : RAMWR;
        end else if (xfer_s) begin
          hdr_nx = hdr_r + 3'd1;
        end else begin
          hdr_nx = hdr_r;
        end
      end
      RAMWR: begin
        if (xfer_s) state_nx = PIXELS;
        else        state_nx = RAMWR;
      end
      PIXELS: begin
        if (xfer_s && last_s) begin
          state_nx = DONE;  start_nx = 1'b0;  busy_nx = 1'b0;  done_nx = 1'b1;
        end else if (xfer_s && bidx_r != BIDX_MAX) begin
          bidx_nx = bidx_r + 2'd1;
        end else if (xfer_s) begin
          // Odometer: pixel -> cell column -> line in cell -> cell row
          bidx_nx = 2'd0;
          if (px_r != PX_MAX) begin
            px_nx = px_r + PXW'(1);
          end else begin
            px_nx = '0;
            if (col_r != COL_MAX) begin
              col_nx = col_r + CXW'(1);
            end else begin
              col_nx = '0;
              if (py_r != PY_MAX) begin
                py_nx = py_r + PYW'(1);
              end else begin
                py_nx  = '0;
                row_nx = row_r + RYW'(1);
              end
            end
          end
        end else begin
          bidx_nx = bidx_r;
        end
      end
      DONE:    begin state_nx = IDLE;  start_nx = 1'b0;  busy_nx = 1'b0; end
      default: begin state_nx = IDLE;  start_nx = 1'b0;  busy_nx = 1'b0; end
    endcase
  end

  // Pattern colour of the pixel that will be presented next
  always_comb begin
    case (mode_r)
      MODE_COL:   sel_s = col_nx[0];
      MODE_ROW:   sel_s = row_nx[0];
      MODE_CHECK: sel_s = col_nx[0] ^ row_nx[0];
      MODE_SOLID: sel_s = 1'b0;
      default:    sel_s = 1'b0;
    endcase
`ifdef LCD_GRID_BORDER_EN
    if (px_nx == '0 || py_nx == '0) color_s = border_r;
    else                            color_s = sel_s ? p2_r : p1_r;
`else
    color_s = sel_s ? p2_r : p1_r;
`endif
  end

  lcd_pixel_fmt u_fmt (
    .color    (color_s),
    .byte_idx (bidx_nx),
    .fmt      (FMT),
    .data     (pix_byte_s)
  );

  // Byte and D/C for the next presented position
  always_comb begin
    data_nx = 8'h00;
    dc_nx   = 1'b0;
    case (state_nx)
      CASET: begin
        data_nx = (hdr_nx == 3'd0) ? CMD_CASET : coord_byte(XS, XE, hdr_nx);
        dc_nx   = (hdr_nx != 3'd0);
      end
      RASET: begin
        data_nx = (hdr_nx == 3'd0) ? CMD_RASET : coord_byte(YS, YE, hdr_nx);
        dc_nx   = (hdr_nx != 3'd0);
      end
      RAMWR:   begin data_nx = CMD_RAMWR;   dc_nx = 1'b0; end
      PIXELS:  begin data_nx = pix_byte_s;  dc_nx = 1'b1; end
      default: begin data_nx = 8'h00;       dc_nx = 1'b0; end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;  hdr_r <= 3'd0;  bidx_r <= 2'd0;
      px_r <= '0;  col_r <= '0;  py_r <= '0;  row_r <= '0;
      busy_r <= 1'b0;  done_r <= 1'b0;  start_r <= 1'b0;  data_r <= 8'h00;  dc_r <= 1'b0;
      mode_r <= MODE_COL;  p1_r <= 24'h000000;  p2_r <= 24'h000000;
`ifdef LCD_GRID_BORDER_EN
      border_r <= 24'h000000;
`endif
    end else begin
      state_r <= state_nx;  hdr_r <= hdr_nx;  bidx_r <= bidx_nx;
      px_r <= px_nx;  col_r <= col_nx;  py_r <= py_nx;  row_r <= row_nx;
      busy_r <= busy_nx;  done_r <= done_nx;  start_r <= start_nx;
      data_r <= data_nx;  dc_r <= dc_nx;
      mode_r <= mode_nx;  p1_r <= p1_nx;  p2_r <= p2_nx;
`ifdef LCD_GRID_BORDER_EN
      border_r <= border_nx;
`endif
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.spi_start = start_r;
  assign bus.spi_data  = data_r;
  assign bus.spi_dc    = dc_r;

endmodule

// File: tb/tb_lcd_grid_draw.sv
// Bench for lcd_grid_draw: three instances (default geometry, small RGB565,
// small RGB888) checked against a raster-order reference model.
module tb_lcd_grid_draw;

  localparam int NDUT = 3;
  localparam int CAP  = 160;

`ifdef LCD_GRID_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  int g_rows[NDUT] = '{5, 2, 3};
  int g_cols[NDUT] = '{8, 2, 2};
  int g_cw[NDUT]   = '{30, 2, 3};
  int g_ch[NDUT]   = '{27, 2, 2};
  int g_xo[NDUT]   = '{40, 40, 300};
  int g_yo[NDUT]   = '{53, 53, 0};
  int g_bpp[NDUT]  = '{2, 2, 3};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rdy = 1'b0;
  logic [1:0]  mode_v = 2'd0;
  logic [23:0] c1 = 24'h0, c2 = 24'h0, bcol = 24'h0;
  logic de[NDUT];
  logic st[NDUT], dcv[NDUT], bsy[NDUT], dn[NDUT];
  logic [7:0] dat[NDUT];

  lcd_grid_draw_if bus0 ();
  lcd_grid_draw_if bus1 ();
  lcd_grid_draw_if bus2 ();

  lcd_grid_draw dut0 (.clk(clk), .reset(reset), .bus(bus0));
  lcd_grid_draw #(.GRID_ROWS(2), .GRID_COLS(2), .CELL_W(2), .CELL_H(2),
                  .X_OFFSET(40), .Y_OFFSET(53), .PIX_FMT(0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  lcd_grid_draw #(.GRID_ROWS(3), .GRID_COLS(2), .CELL_W(3), .CELL_H(2),
                  .X_OFFSET(300), .Y_OFFSET(0), .PIX_FMT(1))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus0.draw_en = de[0];  assign bus1.draw_en = de[1];  assign bus2.draw_en = de[2];
  assign bus0.mode = mode_v;    assign bus1.mode = mode_v;    assign bus2.mode = mode_v;
  assign bus0.color_p1 = c1;    assign bus1.color_p1 = c1;    assign bus2.color_p1 = c1;
  assign bus0.color_p2 = c2;    assign bus1.color_p2 = c2;    assign bus2.color_p2 = c2;
  assign bus0.spi_ready = rdy;  assign bus1.spi_ready = rdy;  assign bus2.spi_ready = rdy;
`ifdef LCD_GRID_BORDER_EN
  assign bus0.border_color = bcol;
  assign bus1.border_color = bcol;
  assign bus2.border_color = bcol;
`endif
  assign st[0] = bus0.spi_start;  assign st[1] = bus1.spi_start;  assign st[2] = bus2.spi_start;
  assign dat[0] = bus0.spi_data;  assign dat[1] = bus1.spi_data;  assign dat[2] = bus2.spi_data;
  assign dcv[0] = bus0.spi_dc;    assign dcv[1] = bus1.spi_dc;    assign dcv[2] = bus2.spi_dc;
  assign bsy[0] = bus0.busy;      assign bsy[1] = bus1.busy;      assign bsy[2] = bus2.busy;
  assign dn[0] = bus0.done;       assign dn[1] = bus1.done;       assign dn[2] = bus2.done;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int pct = 100;
  logic mon_en[NDUT];
  logic stall_p[NDUT];
  logic [8:0] stall_v[NDUT];
  logic [8:0] exp_mem[NDUT][CAP];
  logic [8:0] act_mem[NDUT][CAP];
  int exp_n[NDUT];
  int act_n[NDUT];
  int done_cnt[NDUT];

  typedef struct packed { logic dc; logic [7:0] data; } hdr_t;
  typedef struct packed {
    logic [1:0]  mode;
    logic [23:0] p1;
    logic [23:0] p2;
    logic [23:0] border;
    logic [7:0]  pct;
    logic [63:0] row0;
  } frame_vec_t;

  hdr_t hdr_tab[11];
  frame_vec_t ftab[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One cycle: sample outputs at the falling edge, pick ready for the next rising edge
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (mon_en[k] && stall_p[k])
        check($sformatf("stall_hold_dut%0d", k), {54'd0, st[k], dcv[k], dat[k]},
              {54'd0, 1'b1, stall_v[k]});
      if (mon_en[k] && dn[k]) done_cnt[k]++;
    end
    rdy = (int'($urandom_range(99)) < pct);
    for (int k = 0; k < NDUT; k++) begin
      stall_p[k] = mon_en[k] && st[k] && !rdy;
      stall_v[k] = {dcv[k], dat[k]};
      if (mon_en[k] && st[k] && rdy && act_n[k] < CAP) begin
        act_mem[k][act_n[k]] = {dcv[k], dat[k]};
        act_n[k]++;
      end
    end
  endtask

  task automatic push(input int k, input logic [8:0] v);
    if (exp_n[k] < CAP) exp_mem[k][exp_n[k]] = v;
    exp_n[k]++;
  endtask

  // Reference stream: window header then every pixel in raster order
  task automatic build_exp(input int k, input logic [1:0] m, input logic [23:0] a,
                           input logic [23:0] b, input logic [23:0] bc);
    logic [15:0] xs, xe, ys, ye, wd;
    logic [23:0] c;
    int w, h, cx, cy, sel, r, g, bl;
    w = g_cols[k] * g_cw[k];
    h = g_rows[k] * g_ch[k];
    xs = 16'(g_xo[k]);  xe = 16'(g_xo[k] + w - 1);
    ys = 16'(g_yo[k]);  ye = 16'(g_yo[k] + h - 1);
    exp_n[k] = 0;
    push(k, {1'b0, 8'h2A}); push(k, {1'b1, xs[15:8]}); push(k, {1'b1, xs[7:0]});
    push(k, {1'b1, xe[15:8]}); push(k, {1'b1, xe[7:0]});
    push(k, {1'b0, 8'h2B}); push(k, {1'b1, ys[15:8]}); push(k, {1'b1, ys[7:0]});
    push(k, {1'b1, ye[15:8]}); push(k, {1'b1, ye[7:0]});
    push(k, {1'b0, 8'h2C});
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        cx = x / g_cw[k];
        cy = y / g_ch[k];
        case (m)
          2'd0:    sel = cx % 2;
          2'd1:    sel = cy % 2;
          2'd2:    sel = (cx + cy) % 2;
          default: sel = 0;
        endcase
        c = (sel != 0) ? b : a;
        if (BORDER && ((x % g_cw[k]) == 0 || (y % g_ch[k]) == 0)) c = bc;
        r = int'(c[23:16]);  g = int'(c[15:8]);  bl = int'(c[7:0]);
        if (g_bpp[k] == 3) begin
          push(k, {1'b1, c[23:16]}); push(k, {1'b1, c[15:8]}); push(k, {1'b1, c[7:0]});
        end else begin
          wd = 16'((r / 8) * 2048 + (g / 4) * 32 + (bl / 8));
          push(k, {1'b1, wd[15:8]}); push(k, {1'b1, wd[7:0]});
        end
      end
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] bc, input int p);
    int cnt, mism, first;
    mode_v = m;  c1 = a;  c2 = b;  bcol = bc;  pct = p;
    for (int k = 1; k < NDUT; k++) begin
      build_exp(k, m, a, b, bc);
      act_n[k] = 0;  done_cnt[k] = 0;  stall_p[k] = 1'b0;  mon_en[k] = 1'b1;
    end
    de[1] = 1'b1;  de[2] = 1'b1;
    tick();
    de[1] = 1'b0;  de[2] = 1'b0;
    cnt = 0;
    while ((done_cnt[1] == 0 || done_cnt[2] == 0) && cnt < 4000) begin
      if (cnt == 12) begin
        // A second start while busy and changed colour inputs must not disturb the frame
        de[1] = 1'b1;  de[2] = 1'b1;  c1 = ~a;  c2 = ~b;  bcol = ~bc;  mode_v = ~m;
      end else begin
        de[1] = 1'b0;  de[2] = 1'b0;
      end
      tick();
      cnt++;
    end
    de[1] = 1'b0;  de[2] = 1'b0;
    check("frame_timeout", 64'(cnt >= 4000), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    for (int k = 1; k < NDUT; k++) begin
      check($sformatf("done_pulses_dut%0d", k), 64'(done_cnt[k]), 64'd1);
      check($sformatf("busy_after_dut%0d", k), 64'(bsy[k]), 64'd0);
      check($sformatf("byte_count_dut%0d", k), 64'(act_n[k]), 64'(exp_n[k]));
      mism = 0;  first = -1;
      for (int i = 0; i < act_n[k] && i < exp_n[k]; i++) begin
        if (act_mem[k][i] !== exp_mem[k][i]) begin
          mism++;
          if (first < 0) first = i;
        end
      end
      n_chk++;
      if (mism != 0) begin
        n_fail++;
        $display("FAIL stream_dut%0d: %0d wrong bytes, first at %0d got %03h expected %03h",
                 k, mism, first, act_mem[k][first], exp_mem[k][first]);
      end
      mon_en[k] = 1'b0;  stall_p[k] = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    logic [15:0] wd;
    for (int k = 0; k < NDUT; k++) begin
      de[k] = 1'b0;  mon_en[k] = 1'b0;  stall_p[k] = 1'b0;
      act_n[k] = 0;  exp_n[k] = 0;  done_cnt[k] = 0;
    end
    hdr_tab[0] = {1'b0, 8'h2A};  hdr_tab[1] = {1'b1, 8'h00};  hdr_tab[2] = {1'b1, 8'h28};
    hdr_tab[3] = {1'b1, 8'h01};  hdr_tab[4] = {1'b1, 8'h17};  hdr_tab[5] = {1'b0, 8'h2B};
    hdr_tab[6] = {1'b1, 8'h00};  hdr_tab[7] = {1'b1, 8'h35};  hdr_tab[8] = {1'b1, 8'h00};
    hdr_tab[9] = {1'b1, 8'hBB};  hdr_tab[10] = {1'b0, 8'h2C};
`ifdef LCD_GRID_BORDER_EN
    ftab[0] = {2'd2, 24'hFF0000, 24'h0000FF, 24'hFFFFFF, 8'd100, 64'hFFFF_FFFF_FFFF_FFFF};
    ftab[1] = {2'd0, 24'h00FF00, 24'h123456, 24'hFFFFFF, 8'd100, 64'hFFFF_FFFF_FFFF_FFFF};
    ftab[2] = {2'd1, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 8'd50,  64'hFFFF_FFFF_FFFF_FFFF};
    ftab[3] = {2'd3, 24'h808080, 24'h00FF00, 24'hFFFFFF, 8'd40,  64'hFFFF_FFFF_FFFF_FFFF};
`else
    ftab[0] = {2'd2, 24'hFF0000, 24'h0000FF, 24'h000000, 8'd100, 64'hF800_F800_001F_001F};
    ftab[1] = {2'd0, 24'h00FF00, 24'h123456, 24'h000000, 8'd100, 64'h07E0_07E0_11AA_11AA};
    ftab[2] = {2'd1, 24'hFFFFFF, 24'h000000, 24'h000000, 8'd50,  64'hFFFF_FFFF_FFFF_FFFF};
    ftab[3] = {2'd3, 24'h808080, 24'h00FF00, 24'h000000, 8'd40,  64'h8410_8410_8410_8410};
`endif

    // Reset state of every instance
    for (int i = 0; i < 3; i++) tick();
    for (int k = 0; k < NDUT; k++)
      check($sformatf("reset_outputs_dut%0d", k),
            {52'd0, bsy[k], dn[k], st[k], dcv[k], dat[k]}, 64'd0);
    reset = 1'b1;
    tick();

    // Default-geometry header bytes
    pct = 100;  mon_en[0] = 1'b1;  de[0] = 1'b1;
    tick();
    de[0] = 1'b0;
    cnt = 0;
    while (act_n[0] < 11 && cnt < 100) begin tick(); cnt++; end
    check("header_timeout", 64'(cnt >= 100), 64'd0);
    for (int i = 0; i < 11; i++)
      check($sformatf("header_byte%0d", i), 64'(act_mem[0][i]), 64'(hdr_tab[i]));
    for (int i = 0; i < 5; i++) tick();
    check("busy_in_pixels", 64'(bsy[0]), 64'd1);

    // Reset in the middle of the pixel stream, then a clean restart
    mon_en[0] = 1'b0;  stall_p[0] = 1'b0;  reset = 1'b0;
    tick();
    check("midframe_reset", {61'd0, st[0], bsy[0], dn[0]}, 64'd0);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (dn[0]) cnt++; end
    check("no_done_after_abort", 64'(cnt), 64'd0);
    act_n[0] = 0;  mon_en[0] = 1'b1;  de[0] = 1'b1;
    tick();
    de[0] = 1'b0;
    cnt = 0;
    while (act_n[0] < 1 && cnt < 50) begin tick(); cnt++; end
    check("restart_first_byte", 64'(act_mem[0][0]), 64'({1'b0, 8'h2A}));
    mon_en[0] = 1'b0;  stall_p[0] = 1'b0;  reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Table-driven frames on the small instances
    for (int t = 0; t < 4; t++) begin
      run_frame(ftab[t].mode, ftab[t].p1, ftab[t].p2, ftab[t].border, int'(ftab[t].pct));
      for (int j = 0; j < 4; j++) begin
        wd = {act_mem[1][11 + 2 * j][7:0], act_mem[1][12 + 2 * j][7:0]};
        check($sformatf("vec%0d_row0_word%0d", t, j), 64'(wd),
              64'(ftab[t].row0[63 - 16 * j -: 16]));
      end
    end

    // Randomised frames with random backpressure
    for (int t = 0; t < 8; t++)
      run_frame(2'($urandom_range(3)), 24'($urandom), 24'($urandom), 24'($urandom),
                int'($urandom_range(100, 25)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_grid_draw.md
Name: lcd_grid_draw

Overview:
- Parametrised successor to the grid painter: streams a full-window colour grid to an ST7789-class LCD through the byte-wide SPI sender.
- Issues window setup (CASET/RASET), then RAMWR, then every pixel of the grid area.
- Supports four pattern modes, RGB565 or RGB888 pixel format, and a display offset.
- Sits between the top-level control FSM (draw_en/done) and the SPI byte transmitter.

Parameters:
- GRID_ROWS, 5, number of cell rows
- GRID_COLS, 8, number of cell columns
- CELL_W, 30, cell width in pixels
- CELL_H, 27, cell height in pixels
- X_OFFSET, 40, panel column offset added to all X addresses
- Y_OFFSET, 53, panel row offset added to all Y addresses
- PIX_FMT, 0, pixel format: 0 = RGB565 (2 bytes/pixel), 1 = RGB888 (3 bytes/pixel)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- draw_en  in  1  start request, level-sampled in IDLE
- mode  in  2  pattern: 0 = column stripes, 1 = row stripes, 2 = checker, 3 = solid color_p1
- color_p1  in  24  colour A, {R,G,B} 8 bits each
- color_p2  in  24  colour B
- busy  out  1  high from accept of start until done
- done  out  1  one-cycle pulse after the last byte is accepted
- spi_start  out  1  byte valid
- spi_data  out  8  byte to send
- spi_dc  out  1  0 = command byte, 1 = data byte
- spi_ready  in  1  SPI sender can accept a byte

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; busy=0, done=0, spi_start=0, spi_data=0, spi_dc=0; all counters 0. This applies mid-frame as well: the frame is abandoned and there is no resume.
- Handshake: a byte transfers on any edge where spi_start && spi_ready. spi_data and spi_dc are held stable while spi_start=1 and spi_ready=0. After a transfer, the next byte may be presented on the following cycle. spi_start stays 1 back-to-back while bytes remain.
- IDLE:
  - If draw_en=1, latch mode, color_p1 and color_p2; set busy=1; go to CASET.
  - draw_en while busy is ignored.
  - done is never asserted without a frame.
- Window bounds: XS=X_OFFSET, XE=X_OFFSET+GRID_COLS*CELL_W-1, YS=Y_OFFSET, YE=Y_OFFSET+GRID_ROWS*CELL_H-1. All are 16-bit, sent MSB first.
- Byte sequence:
  - CASET: cmd 0x2A (dc=0), then XS[15:8], XS[7:0], XE[15:8], XE[7:0] (dc=1).
  - RASET: cmd 0x2B, then YS and YE in the same layout.
  - RAMWR: cmd 0x2C.
  - PIXELS: dc=1, raster order, left to right then top to bottom.
- Byte counts:
  - Total pixels = GRID_COLS*CELL_W*GRID_ROWS*CELL_H (32400 at defaults).
  - Total bytes = 11 + pixels*(2 or 3); 64811 for RGB565 at defaults.
- Pixel counters:
  - px_in_cell, col_idx, py_in_cell, row_idx, byte_idx. No division or modulo is used.
  - px_in_cell wraps at CELL_W-1 and increments col_idx.
  - col_idx wraps at GRID_COLS-1; that advances py_in_cell, which wraps at CELL_H-1 into row_idx.
- Colour select (sel=0 → color_p1, sel=1 → color_p2):
  - mode 0: sel = col_idx[0]
  - mode 1: sel = row_idx[0]
  - mode 2: sel = col_idx[0]^row_idx[0]
  - mode 3: sel = 0
- RGB565 encoding: word = {R[7:3],G[7:2],B[7:3]}; high byte first.
- RGB888 encoding: bytes R, G, B.
- Frame end: the last pixel byte transfers at row_idx=GRID_ROWS-1 with all inner counters at their maximum. Next state is DONE: done=1 for one cycle, busy=0, spi_start=0, then IDLE. A new draw_en may be accepted on the cycle after DONE.
- spi_ready held low indefinitely: the block stalls with no timeout; outputs stay held.

Optional Feature:
- Macro: LCD_GRID_BORDER_EN.
- Defined: extra input border_color (24 bits) is latched at start. Pixels with px_in_cell==0 or py_in_cell==0 use border_color regardless of mode.
- Undefined: no port and no border logic; pattern exactly as above.

Decomposition:
- Package lcd_pkg:
  - ST7789 command constants CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C
  - FSM state encoding (IDLE, CASET, RASET, RAMWR, PIXELS, DONE)
  - PIX_FMT codes and mode codes
- Sub-module lcd_pixel_fmt: combinational 24-bit colour + byte_idx + format → spi_data byte. Also reused by the future sprite/text painters.

Test Plan:
- Header bytes (defaults, spi_ready always 1, draw_en pulse): first 11 bytes = 2A, 00, 28, 01, 17, 2B, 00, 35, 00, BB, 2C. dc = 0 on bytes 1, 6 and 11 only.
- Mode 2, RGB565, p1=FF0000, p2=0000FF, GRID 2x2, CELL 2x2: pixel words F800, F800, 001F, 001F (row 0), repeated for row 1, then 001F, 001F, F800, F800 for rows 2–3. done pulses once after 11+32 bytes.
- PIX_FMT=1, mode 3, p1=123456: every pixel = 12, 34, 56; byte count = 11+3*pixels.
- Backpressure: spi_ready toggled pseudo-randomly. spi_data and spi_dc stay stable while stalled; the stream is identical to the no-stall run.
- Reset pulled low mid-PIXELS: next edge gives spi_start=0, busy=0 and no done pulse. A fresh draw_en restarts with byte 2A.
- LCD_GRID_BORDER_EN, border=FFFFFF, mode 0: the first column and first row of each cell are FFFF; other pixels follow column stripes.
